// File: rtl/fb_pingpong_ctrl_pkg.sv
// Shared frame geometry and controller state encoding for the frame-buffer block.
// The VGA block imports the same geometry for its address math.
package fb_pkg;

    localparam int PIXEL_COLUMN = 80;
    localparam int PIXEL_ROW    = 60;
    localparam int FRAME_WORDS  = PIXEL_COLUMN * PIXEL_ROW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL0,
        S_RUN,
        S_HOLD
    } state_t;

endpackage

// File: rtl/fb_pingpong_ctrl_if.sv
// Producer pixel stream: one beat per cycle when valid & ready.
// sof marks the first pixel of a frame.
interface fb_pingpong_ctrl_if #(
    parameter int DATA_W = 16
) ();

    logic              valid;
    logic              sof;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output sof, output data, input  ready);
    modport slave  (input  valid, input  sof, input  data, output ready);

endinterface

// File: rtl/fb_bank_mux.sv
// Combinational steering between the two RAM banks.
// The back bank gets the write pointer and write enable. The front bank gets the
// range-checked VGA address, and its read data goes back to the VGA engine.
// When both selects point at the same bank (before display starts), the write side wins.
module fb_bank_mux
    import fb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int VADDR_W = 20,
    parameter int BADDR_W = 13
) (
    input  logic               front_sel,
    input  logic               back_sel,
    input  logic               we,
    input  logic [BADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [VADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0]  vga_data,
    output logic [BADDR_W-1:0] bank0_addr,
    output logic               bank0_we,
    output logic [DATA_W-1:0]  bank0_wdata,
    input  logic [DATA_W-1:0]  bank0_rdata,
    output logic [BADDR_W-1:0] bank1_addr,
    output logic               bank1_we,
    output logic [DATA_W-1:0]  bank1_wdata,
    input  logic [DATA_W-1:0]  bank1_rdata
);

    logic [BADDR_W-1:0] rd_addr;

    // Any VGA address outside the frame (including stray high bits) reads word 0.
    assign rd_addr = (vga_addr < VADDR_W'(FRAME_WORDS)) ? vga_addr[BADDR_W-1:0] : '0;

    assign bank0_addr  = back_sel ? rd_addr : wr_addr;
    assign bank1_addr  = back_sel ? wr_addr : rd_addr;
    assign bank0_we    = we & ~back_sel;
    assign bank1_we    = we &  back_sel;
    assign bank0_wdata = wdata;
    assign bank1_wdata = wdata;
    assign vga_data    = front_sel ? bank1_rdata : bank0_rdata;

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame-buffer controller.
// The producer fills the back bank while VGA reads the front bank. The banks swap
// on a VGA end-of-frame pulse, and only once the back bank holds a complete frame.
module fb_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int VADDR_W = 20,
    parameter int BADDR_W = 13
) (
    input  logic               i_clk_25M,
    input  logic               i_rst,
    input  logic               i_enable,
    fb_pingpong_ctrl_if.slave  wr,
    output logic               o_start_display,
    input  logic [VADDR_W-1:0] i_vga_addr,
    input  logic               i_vga_finish,
    output logic [DATA_W-1:0]  o_vga_data,
    output logic [BADDR_W-1:0] o_bank0_addr,
    output logic               o_bank0_we,
    output logic [DATA_W-1:0]  o_bank0_wdata,
    input  logic [DATA_W-1:0]  i_bank0_rdata,
    output logic [BADDR_W-1:0] o_bank1_addr,
    output logic               o_bank1_we,
    output logic [DATA_W-1:0]  o_bank1_wdata,
    input  logic [DATA_W-1:0]  i_bank1_rdata,
    output logic               o_front_bank,
    output logic               o_swap,
    output logic [15:0]        o_drop_cnt
);

    localparam logic [BADDR_W-1:0] LAST_PTR = BADDR_W'(FRAME_WORDS - 1);

    state_t             state, state_nxt;
    logic [BADDR_W-1:0] wr_ptr, wr_addr;
    logic               back_full, back_full_nxt;
    logic               ready, ready_nxt;
    logic               front, start, swap;
    logic [15:0]        drop_cnt;
    logic               accept, last_beat, hold_finish, fill_done, back_sel;

    assign accept      = wr.valid & ready;
    assign last_beat   = accept & ~wr.sof & (wr_ptr == LAST_PTR);
    assign hold_finish = (state == S_HOLD) & i_vga_finish;
    assign fill_done   = (state == S_FILL0) & back_full;
    // Until display runs, front and back are both bank 0.
    assign back_sel    = (state == S_RUN || state == S_HOLD) ? ~front : 1'b0;
    // A sof beat always lands at address 0, whatever the pointer held.
    assign wr_addr     = (accept & wr.sof) ? '0 : wr_ptr;

    // Next-state logic. Ready is precomputed here so that it drops the cycle after the last beat.
    always_comb begin
        state_nxt     = state;
        back_full_nxt = back_full;
        case (state)
            S_IDLE:  if (i_enable) state_nxt = S_FILL0;
            S_FILL0: if (back_full) begin
                         state_nxt     = S_RUN;
                         back_full_nxt = 1'b0;
                     end
            S_RUN:   if (back_full) state_nxt = S_HOLD;
            S_HOLD:  if (i_vga_finish) begin
                         state_nxt     = S_RUN;
                         back_full_nxt = 1'b0;
                     end
            default: state_nxt = S_IDLE;
        endcase
        if (last_beat) back_full_nxt = 1'b1;
        ready_nxt = (state_nxt == S_FILL0 || state_nxt == S_RUN) && !back_full_nxt;
    end

    // State, handshake and bank-select registers.
    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            back_full <= 1'b0;
            ready     <= 1'b0;
            front     <= 1'b0;
            start     <= 1'b0;
            swap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            back_full <= back_full_nxt;
            ready     <= ready_nxt;
            swap      <= hold_finish;
            if (hold_finish)    front <= ~front;
            else if (fill_done) front <= 1'b0;
            if (fill_done)      start <= 1'b1;
        end
    end

    // Write pointer: sof resyncs to 1, the last word wraps to 0, and a swap rewinds.
    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst)                        wr_ptr <= '0;
        else if (hold_finish)             wr_ptr <= '0;
        else if (accept && wr.sof)        wr_ptr <= BADDR_W'(1);
        else if (last_beat)               wr_ptr <= '0;
        else if (accept)                  wr_ptr <= wr_ptr + BADDR_W'(1);
    end

    // Count VGA frames that repeat because the back bank was not ready. Saturates at the top.
    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst)
            drop_cnt <= '0;
        else if (state == S_RUN && !back_full && i_vga_finish && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

    fb_bank_mux #(.DATA_W(DATA_W), .VADDR_W(VADDR_W), .BADDR_W(BADDR_W)) u_mux (
        .front_sel   (front),
        .back_sel    (back_sel),
        .we          (accept),
        .wr_addr     (wr_addr),
        .wdata       (wr.data),
        .vga_addr    (i_vga_addr),
        .vga_data    (o_vga_data),
        .bank0_addr  (o_bank0_addr),
        .bank0_we    (o_bank0_we),
        .bank0_wdata (o_bank0_wdata),
        .bank0_rdata (i_bank0_rdata),
        .bank1_addr  (o_bank1_addr),
        .bank1_we    (o_bank1_we),
        .bank1_wdata (o_bank1_wdata),
        .bank1_rdata (i_bank1_rdata)
    );

    assign wr.ready        = ready;
    assign o_start_display = start;
    assign o_front_bank    = front;
    assign o_swap          = swap;
    assign o_drop_cnt      = drop_cnt;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed bench for fb_pingpong_ctrl. The bench models both banks as async-read RAMs.
// Pixel values encode a frame tag in bits [15:13] and the pixel index below that.
module tb_fb_pingpong_ctrl;

    localparam int FW = 4800;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start_display;
    logic [19:0] vga_addr;
    logic        vga_finish;
    logic [15:0] vga_data;
    logic [12:0] b0_addr, b1_addr;
    logic        b0_we, b1_we;
    logic [15:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata;
    logic        front_bank, swap;
    logic [15:0] drop_cnt;

    logic [15:0] mem0 [0:FW-1];
    logic [15:0] mem1 [0:FW-1];

    int n_chk = 0;
    int n_err = 0;
    bit stuck = 1'b0;

    fb_pingpong_ctrl_if #(.DATA_W(16)) wr ();

    fb_pingpong_ctrl dut (
        .i_clk_25M       (clk),
        .i_rst           (rst),
        .i_enable        (enable),
        .wr              (wr.slave),
        .o_start_display (start_display),
        .i_vga_addr      (vga_addr),
        .i_vga_finish    (vga_finish),
        .o_vga_data      (vga_data),
        .o_bank0_addr    (b0_addr),
        .o_bank0_we      (b0_we),
        .o_bank0_wdata   (b0_wdata),
        .i_bank0_rdata   (b0_rdata),
        .o_bank1_addr    (b1_addr),
        .o_bank1_we      (b1_we),
        .o_bank1_wdata   (b1_wdata),
        .i_bank1_rdata   (b1_rdata),
        .o_front_bank    (front_bank),
        .o_swap          (swap),
        .o_drop_cnt      (drop_cnt)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (b0_we) mem0[int'(b0_addr)] <= b0_wdata;
        if (b1_we) mem1[int'(b1_addr)] <= b1_wdata;
    end
    assign b0_rdata = mem0[int'(b0_addr)];
    assign b1_rdata = mem1[int'(b1_addr)];

    function automatic logic [15:0] pix(input int tag, input int i);
        return 16'(tag * 8192 + i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One beat: wait (bounded) for ready, then hold the beat through one accepting edge.
    task automatic push(input logic [15:0] d, input logic s, input logic fin = 1'b0);
        int t = 0;
        if (stuck) return;
        wr.valid = 1'b1;
        wr.data  = d;
        wr.sof   = s;
        while (!wr.ready && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) begin
            chk("ready_timeout", 0, 1);
            stuck = 1'b1;
        end
        vga_finish = fin;
        step();
        wr.valid   = 1'b0;
        wr.sof     = 1'b0;
        vga_finish = 1'b0;
    endtask

    task automatic stream(input int n, input int first, input int tag, input logic sof_first);
        for (int k = 0; k < n; k++) push(pix(tag, first + k), sof_first && k == 0);
    endtask

    task automatic finish_pulse();
        vga_finish = 1'b1;
        step();
        vga_finish = 1'b0;
    endtask

    task automatic chk_bank(input int b, input int tag, input string name);
        int bad = 0;
        for (int i = 0; i < FW; i++)
            if ((b ? mem1[i] : mem0[i]) !== pix(tag, i)) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        for (int i = 0; i < FW; i++) begin
            mem0[i] = 16'hDEAD;
            mem1[i] = 16'hDEAD;
        end
        rst = 1'b1; enable = 1'b0; vga_finish = 1'b0; vga_addr = 20'd5;
        wr.valid = 1'b0; wr.sof = 1'b0; wr.data = '0;
        step(3);
        chk("rst_ready", wr.ready, 0);
        chk("rst_start", start_display, 0);
        chk("rst_front", front_bank, 0);
        chk("rst_swap", swap, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        step();

        // 1: first frame into bank0, display starts
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("t1_ready_on", wr.ready, 1);
        stream(FW, 0, 1, 1'b1);
        chk("t1_ready_drop", wr.ready, 0);
        chk("t1_start_pre", start_display, 0);
        step();
        chk("t1_start", start_display, 1);
        chk("t1_ready_run", wr.ready, 1);
        chk_bank(0, 1, "t1_bank0");
        chk("t1_bank1_clean", mem1[0], 16'hDEAD);
        chk("t1_vga", vga_data, pix(1, 5));

        // 2: fill bank1, swap on finish
        stream(FW, 0, 2, 1'b1);
        chk("t2_ready_drop", wr.ready, 0);
        step();
        chk_bank(1, 2, "t2_bank1");
        chk("t2_front_hold", front_bank, 0);
        chk("t2_vga_hold", vga_data, pix(1, 5));
        finish_pulse();
        chk("t2_swap", swap, 1);
        chk("t2_front", front_bank, 1);
        chk("t2_vga", vga_data, pix(2, 5));
        chk("t2_ready", wr.ready, 1);
        step();
        chk("t2_swap_end", swap, 0);
        chk("t2_drop", drop_cnt, 0);

        // 3: partial frame at a finish counts a drop; writing resumes where it stopped
        stream(1000, 0, 3, 1'b1);
        finish_pulse();
        chk("t3_noswap", swap, 0);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_front", front_bank, 1);
        chk("t3_last", mem0[999], pix(3, 999));
        chk("t3_untouched", mem0[1000], pix(1, 1000));
        stream(FW - 1000, 1000, 3, 1'b0);
        chk("t3_ready_drop", wr.ready, 0);
        chk_bank(0, 3, "t3_bank0");
        step();
        finish_pulse();
        chk("t3_swap", swap, 1);
        chk("t3_front_sw", front_bank, 0);
        chk("t3_vga", vga_data, pix(3, 5));

        // 4: sof mid-frame resyncs to address 0
        stream(2000, 0, 4, 1'b1);
        push(pix(5, 0), 1'b1);
        chk("t4_sof_addr0", mem1[0], pix(5, 0));
        chk("t4_ptr_untouched", mem1[2000], pix(2, 2000));
        stream(FW - 2, 1, 5, 1'b0);
        chk("t4_not_full", wr.ready, 1);
        push(pix(5, FW - 1), 1'b0);
        chk("t4_full", wr.ready, 0);
        chk_bank(1, 5, "t4_bank1");
        step();
        finish_pulse();
        chk("t4_front", front_bank, 1);
        chk("t4_drop", drop_cnt, 1);

        // 5: last beat coincides with finish -> drop, swap at the next finish
        stream(FW - 1, 0, 6, 1'b1);
        push(pix(6, FW - 1), 1'b0, 1'b1);
        chk("t5_noswap", swap, 0);
        chk("t5_drop", drop_cnt, 2);
        chk("t5_front", front_bank, 1);
        chk("t5_ready", wr.ready, 0);
        step();
        chk("t5_vga_old", vga_data, pix(5, 5));
        finish_pulse();
        chk("t5_swap", swap, 1);
        chk("t5_front_sw", front_bank, 0);
        chk("t5_vga_new", vga_data, pix(6, 5));
        chk("t5_lastword", mem0[FW - 1], pix(6, FW - 1));

        // 6: reach S_HOLD with front=1, check front address range, then reset
        stream(FW, 0, 7, 1'b1);
        step();
        finish_pulse();
        chk("t6_front", front_bank, 1);
        stream(FW, 0, 0, 1'b1);
        step();
        chk("t6_hold_ready", wr.ready, 0);
        vga_addr = 20'd4799;
        #1 chk("t6_addr_4799", b1_addr, 13'd4799);
        chk("t6_vga_4799", vga_data, pix(7, 4799));
        vga_addr = 20'd4800;
        #1 chk("t6_addr_4800", b1_addr, 13'd0);
        chk("t6_vga_4800", vga_data, pix(7, 0));
        vga_addr = 20'hFFFFF;
        #1 chk("t6_addr_ffff", b1_addr, 13'd0);
        vga_addr = 20'h02005;
        #1 chk("t6_addr_hi", b1_addr, 13'd0);
        chk("t6_back_addr", b0_addr, 13'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", wr.ready, 0);
        chk("t6_rst_start", start_display, 0);
        chk("t6_rst_front", front_bank, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        step();
        chk("t6_rst_swap", swap, 0);
        chk("t6_rst_start2", start_display, 0);
        rst = 1'b0;
        step();
        chk("t6_idle_ready", wr.ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
